// File: rtl/iter_shifter.sv
// Bit-serial 5-bit logical shifter: one position per clock, done pulse d+1 cycles after the accepting edge.
// No backpressure: start is sampled only in IDLE; requests arriving while busy or done are dropped.
module iter_shifter (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic [4:0] in,
    input  logic [2:0] distance,
    input  logic       direction,
    output logic       busy,
    output logic       done,
    output logic [4:0] out
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t     state, state_nxt;
    logic [4:0] work, work_nxt;
    logic [2:0] count, count_nxt;
    logic       dir, dir_nxt;
    logic [4:0] out_nxt;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
            work  <= 5'd0;
            count <= 3'd0;
            dir   <= 1'b0;
            out   <= 5'd0;
        end else begin
            state <= state_nxt;
            work  <= work_nxt;
            count <= count_nxt;
            dir   <= dir_nxt;
            out   <= out_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        work_nxt  = work;
        count_nxt = count;
        dir_nxt   = dir;
        out_nxt   = out;
        case (state)
            IDLE: begin
                if (start) begin
                    work_nxt  = in;
                    count_nxt = distance;
                    dir_nxt   = direction;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                // Distances past the word width still run every step; bits simply fall off.
                if (count != 3'd0) begin
                    work_nxt  = dir ? {1'b0, work[4:1]} : {work[3:0], 1'b0};
                    count_nxt = count - 3'd1;
                end else begin
                    out_nxt   = work;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign busy = (state == SHIFT);
    assign done = (state == DONE);

endmodule
